puf_challenge_ctrl: RTL and testbench
=====================================

PUF_CHALLENGE_CTRL -- requirements
Module: puf_challenge_ctrl

Interface
REQ-001 SHALL have parameter N_BITS, default 8: number of response bits per challenge.
REQ-002 SHALL have parameter SEL_W, default 3: width of the RO-pair select.
REQ-003 SHALL have parameter CNT_W, default 8: width of the RO edge counters.
REQ-004 SHALL have parameter THRESH, default 200: edge count at which an RO is declared arrived.
REQ-005 SHALL have parameter TMO_W, default 12: width of the race timeout counter; timeout is 2^TMO_W-1 cycles.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, launch a challenge; sampled only in IDLE.
REQ-009 SHALL have port challenge, input, SEL_W, base pair index; captured on accepted start.
REQ-010 SHALL have port ro_1 and ro_2, inputs, 1 each, pre-synchronised oscillator signals of the selected pair.
REQ-011 SHALL have port arb_resp and arb_finish, inputs, 1 each, from the race arbiter.
REQ-012 SHALL have port arb_out_1 and arb_out_2, outputs, 1 each, arrival levels to the arbiter.
REQ-013 SHALL have port arb_rst, output, 1, active-high arbiter clear.
REQ-014 SHALL have port ro_en, output, 1, oscillator enable; pair_sel, output, SEL_W, selected pair.
REQ-015 SHALL have ports busy (1), done (1-cycle pulse), response (N_BITS), err_tmo (1) and err_tie (1), all outputs.

Function
REQ-016 SHALL implement the FSM states IDLE -> CLEAR -> RACE -> CAPTURE -> (CLEAR | DONE) -> IDLE.
REQ-017 IDLE: start=1 SHALL latch challenge, zero bit_idx, response, err_tmo and err_tie, and go to CLEAR.
REQ-018 CLEAR, one cycle: arb_rst=1, ro_en=0, edge counters and timeout counter zeroed, arb_out_1/2=0.
REQ-019 RACE: ro_en=1 and edge counters SHALL increment on each detected rising edge of ro_1/ro_2.
REQ-020 Edge detect in RACE SHALL use a registered previous value; the first RACE cycle SHALL not count.
REQ-021 Counters SHALL saturate at THRESH; arb_out_x=1 while counter_x==THRESH, held until CLEAR.
REQ-022 RACE -> CAPTURE SHALL occur on arb_finish=1.
REQ-023 RACE -> CAPTURE SHALL occur on timeout expiry, setting err_tmo and recording bit 0.
REQ-024 If both counters first reach THRESH in the same cycle, err_tie SHALL set and the bit SHALL be recorded as 0 at CAPTURE.
REQ-025 CAPTURE, one cycle: ro_en=0; response[bit_idx] SHALL take arb_resp unless a timeout or tie occurred this race.
REQ-026 CAPTURE: bit_idx SHALL increment; at bit_idx==N_BITS-1 go to DONE, else go to CLEAR.
REQ-027 pair_sel SHALL equal (challenge_reg + bit_idx) mod 2^SEL_W, wrapping without error.
REQ-028 DONE SHALL assert done for exactly one cycle, then go to IDLE; response and err flags SHALL hold until the next start.
REQ-029 busy SHALL be 1 in every state except IDLE; start outside IDLE SHALL be ignored.
REQ-030 Latency SHALL be, per bit, 1 (CLEAR) + race cycles + 1 (CAPTURE), plus 1 cycle for DONE.

Reset
REQ-031 rst=0 at any time, including mid-race, SHALL force IDLE asynchronously.
REQ-032 Reset SHALL zero every output except arb_rst, which SHALL be 1 while rst=0.
REQ-033 Reset SHALL also zero all internal counters and bit_idx.

Structure
REQ-034 FSM state enum and default parameter constants SHALL live in shared package puf_pkg.
REQ-035 One sub-module, ro_edge_counter (edge detect + saturating counter + arrived flag), SHALL be instantiated twice.

Verification
REQ-036 ro_1 at 3x ro_2 rate, N_BITS=8, challenge=0 -> done after 8 races, response=8'hFF, pair_sel stepped 0..7, no err flags.
REQ-037 Both ROs toggling identically -> err_tie=1, corresponding response bits 0, sequence completes.
REQ-038 ro_1/ro_2 held static -> each bit times out after 4095 cycles, err_tmo=1, response=0.
REQ-039 rst pulsed low mid-RACE at bit 3 -> outputs zero immediately, IDLE, next start restarts from bit 0.
REQ-040 challenge=6 -> pair_sel sequence 6,7,0,1,...,5; start asserted while busy -> no effect.

Source files
------------

// File: rtl/puf_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : puf_pkg
//  Description: Shared FSM state encoding, default parameter values and a
//               small width helper for the PUF challenge controller.
//  Revision   : 1.0 - initial release
// ============================================================================
package puf_pkg;

  // Controller sequencing states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RACE    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } puf_state_e;

  // Default parameter values shared by the controller and its sub-module
  localparam int unsigned DEF_N_BITS = 8;
  localparam int unsigned DEF_SEL_W  = 3;
  localparam int unsigned DEF_CNT_W  = 8;
  localparam int unsigned DEF_THRESH = 200;
  localparam int unsigned DEF_TMO_W  = 12;

  // Index width able to address 0..n-1, never narrower than one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : puf_pkg
`default_nettype wire

// File: rtl/ro_edge_counter.sv
`default_nettype none
// ============================================================================
//  Module     : ro_edge_counter
//  Description: Rising-edge detector and saturating edge counter for one
//               ring oscillator. Flags arrival when the count reaches THRESH
//               and pulses hit_o in the cycle the count steps onto THRESH.
//  Revision   : 1.0 - initial release
// ============================================================================
module ro_edge_counter
  import puf_pkg::*;
#(
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned THRESH = DEF_THRESH
) (
  input  logic clk,
  input  logic rst,        // asynchronous, active low
  input  logic clear_i,    // zero the count and disarm edge detection
  input  logic en_i,       // counting window (race in progress)
  input  logic ro_i,       // pre-synchronised oscillator level
  output logic arrived_o,  // count has reached THRESH
  output logic hit_o       // count steps onto THRESH this cycle
);

  localparam logic [CNT_W-1:0] THR      = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] THR_LAST = CNT_W'(THRESH - 1);

  logic             prev_q;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             rise;

  // The first enabled cycle only arms the detector, so a stale prev_q from
  // before the race can never produce a spurious edge.
  assign rise      = en_i & armed_q & ro_i & ~prev_q;
  assign hit_o     = rise & (cnt_q == THR_LAST);
  assign arrived_o = (cnt_q == THR);

  // Next-state: clear dominates, otherwise arm and count up to saturation
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (clear_i) begin
      cnt_d   = '0;
      armed_d = 1'b0;
    end else if (en_i) begin
      armed_d = 1'b1;
      if (rise && (cnt_q != THR)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Register the previous level, arm flag and count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      prev_q  <= ro_i;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : ro_edge_counter
`default_nettype wire

// File: rtl/puf_challenge_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : puf_challenge_ctrl
//  Description: Sequences N_BITS ring-oscillator races for one challenge.
//               Each race: clear the arbiter, count oscillator edges until
//               one side reaches THRESH (or a timeout), then capture the
//               arbiter decision into the response word.
//  Revision   : 1.0 - initial release
// ============================================================================
module puf_challenge_ctrl
  import puf_pkg::*;
#(
  parameter int unsigned N_BITS = DEF_N_BITS,
  parameter int unsigned SEL_W  = DEF_SEL_W,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned THRESH = DEF_THRESH,
  parameter int unsigned TMO_W  = DEF_TMO_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEL_W-1:0]  challenge,
  input  logic              ro_1,
  input  logic              ro_2,
  input  logic              arb_resp,
  input  logic              arb_finish,
  output logic              arb_out_1,
  output logic              arb_out_2,
  output logic              arb_rst,
  output logic              ro_en,
  output logic [SEL_W-1:0]  pair_sel,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] response,
  output logic              err_tmo,
  output logic              err_tie
);

  localparam int unsigned      IDX_W    = idx_width(N_BITS);
  localparam int unsigned      SUM_W    = (SEL_W > IDX_W) ? SEL_W : IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BITS - 1);
  // Race ends on the (2^TMO_W - 1)th race cycle; the counter starts at 0
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);

  puf_state_e        state_q,    state_d;
  logic [SEL_W-1:0]  chal_q,     chal_d;
  logic [IDX_W-1:0]  bit_idx_q,  bit_idx_d;
  logic [N_BITS-1:0] response_q, response_d;
  logic              err_tmo_q,  err_tmo_d;
  logic              err_tie_q,  err_tie_d;
  logic              race_tmo_q, race_tmo_d;   // timeout in the current race
  logic              race_tie_q, race_tie_d;   // tie in the current race
  logic [TMO_W-1:0]  tmo_cnt_q,  tmo_cnt_d;

  logic              in_clear;
  logic              in_race;
  logic              arrived_1, arrived_2;
  logic              hit_1, hit_2;
  logic [SUM_W-1:0]  sel_sum;

  assign in_clear = (state_q == ST_CLEAR);
  assign in_race  = (state_q == ST_RACE);

  ro_edge_counter #(
    .CNT_W  (CNT_W),
    .THRESH (THRESH)
  ) u_cnt_1 (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (in_clear),
    .en_i      (in_race),
    .ro_i      (ro_1),
    .arrived_o (arrived_1),
    .hit_o     (hit_1)
  );

  ro_edge_counter #(
    .CNT_W  (CNT_W),
    .THRESH (THRESH)
  ) u_cnt_2 (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (in_clear),
    .en_i      (in_race),
    .ro_i      (ro_2),
    .arrived_o (arrived_2),
    .hit_o     (hit_2)
  );

  // Pair index walks from the captured challenge and wraps modulo 2^SEL_W
  assign sel_sum   = SUM_W'(chal_q) + SUM_W'(bit_idx_q);
  assign pair_sel  = sel_sum[SEL_W-1:0];

  // arb_rst follows the reset pin directly so the arbiter is held clear
  // for the whole time reset is low, not just from the next clock edge.
  assign arb_rst   = ~rst | in_clear;
  assign arb_out_1 = arrived_1 & ~in_clear;
  assign arb_out_2 = arrived_2 & ~in_clear;
  assign ro_en     = in_race;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign response  = response_q;
  assign err_tmo   = err_tmo_q;
  assign err_tie   = err_tie_q;

  // Next-state and datapath updates for the challenge sequencer
  always_comb begin
    state_d    = state_q;
    chal_d     = chal_q;
    bit_idx_d  = bit_idx_q;
    response_d = response_q;
    err_tmo_d  = err_tmo_q;
    err_tie_d  = err_tie_q;
    race_tmo_d = race_tmo_q;
    race_tie_d = race_tie_q;
    tmo_cnt_d  = tmo_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          chal_d     = challenge;
          bit_idx_d  = '0;
          response_d = '0;
          err_tmo_d  = 1'b0;
          err_tie_d  = 1'b0;
          state_d    = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        tmo_cnt_d  = '0;
        race_tmo_d = 1'b0;
        race_tie_d = 1'b0;
        state_d    = ST_RACE;
      end
      ST_RACE: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (hit_1 && hit_2) begin
          race_tie_d = 1'b1;
          err_tie_d  = 1'b1;
        end
        if (arb_finish) begin
          state_d = ST_CAPTURE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          race_tmo_d = 1'b1;
          err_tmo_d  = 1'b1;
          state_d    = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        response_d[bit_idx_q] = (race_tmo_q | race_tie_q) ? 1'b0 : arb_resp;
        bit_idx_d             = bit_idx_q + IDX_W'(1);
        state_d               = (bit_idx_q == LAST_IDX) ? ST_DONE : ST_CLEAR;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      chal_q     <= '0;
      bit_idx_q  <= '0;
      response_q <= '0;
      err_tmo_q  <= 1'b0;
      err_tie_q  <= 1'b0;
      race_tmo_q <= 1'b0;
      race_tie_q <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      chal_q     <= chal_d;
      bit_idx_q  <= bit_idx_d;
      response_q <= response_d;
      err_tmo_q  <= err_tmo_d;
      err_tie_q  <= err_tie_d;
      race_tmo_q <= race_tmo_d;
      race_tie_q <= race_tie_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

endmodule : puf_challenge_ctrl
`default_nettype wire

// File: tb/tb_puf_challenge_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : tb_puf_challenge_ctrl
//  Description: Self-checking bench for puf_challenge_ctrl. Oscillators are
//               square waves with a per-bit half period (0 = static), the
//               arbiter latches whichever arrival level rises first.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_puf_challenge_ctrl;

  localparam int NB   = 8;
  localparam int SELW = 3;
  localparam int TMOW = 12;

  typedef struct {
    logic [NB-1:0] resp;
    logic          tmo;
    logic          tie;
    int            lat;    // busy cycles start..done inclusive, -1 = unchecked
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [SELW-1:0] challenge = '0;
  logic            ro_1 = 1'b0, ro_2 = 1'b0;
  logic            arb_resp = 1'b0, arb_finish = 1'b0;
  logic            arb_out_1, arb_out_2, arb_rst, ro_en, busy, done;
  logic            err_tmo, err_tie;
  logic [SELW-1:0] pair_sel;
  logic [NB-1:0]   response;

  exp_t res_q[$];
  int   pair_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   h1_arr[NB];
  int   h2_arr[NB];
  int   drv_bit = 0;

  puf_challenge_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .challenge  (challenge),
    .ro_1       (ro_1),
    .ro_2       (ro_2),
    .arb_resp   (arb_resp),
    .arb_finish (arb_finish),
    .arb_out_1  (arb_out_1),
    .arb_out_2  (arb_out_2),
    .arb_rst    (arb_rst),
    .ro_en      (ro_en),
    .pair_sel   (pair_sel),
    .busy       (busy),
    .done       (done),
    .response   (response),
    .err_tmo    (err_tmo),
    .err_tie    (err_tie)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Oscillator and arbiter environment, updated away from the active edge
  initial begin : env
    int ph;
    int b;
    logic en_prev;
    ph = 0;
    en_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (arb_rst) begin
        arb_finish = 1'b0;
        arb_resp   = 1'b0;
      end else if (!arb_finish && (arb_out_1 || arb_out_2)) begin
        arb_finish = 1'b1;
        arb_resp   = arb_out_1;
      end
      if (!busy) drv_bit = 0;
      else if (en_prev && !ro_en) drv_bit++;
      b = (drv_bit < NB) ? drv_bit : NB - 1;
      if (ro_en) begin
        ph++;
        ro_1 = (h1_arr[b] != 0) ? (((ph / h1_arr[b]) % 2) == 1) : 1'b0;
        ro_2 = (h2_arr[b] != 0) ? (((ph / h2_arr[b]) % 2) == 1) : 1'b0;
      end else begin
        ph   = 0;
        ro_1 = 1'b0;
        ro_2 = 1'b0;
      end
      en_prev = ro_en;
    end
  end

  // Monitor: checks pair_sel at every race start and the result at done
  initial begin : monitor
    exp_t e;
    int   ep;
    int   busy_cyc;
    logic en_prev, done_prev;
    busy_cyc  = 0;
    en_prev   = 1'b0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_cyc  = 0;
        en_prev   = 1'b0;
        done_prev = 1'b0;
      end else begin
        if (busy) busy_cyc++;
        else busy_cyc = 0;
        if (ro_en && !en_prev) begin
          if (pair_q.size() > 0) begin
            ep = pair_q.pop_front();
            check("pair_sel", 32'(pair_sel), 32'(ep));
          end else begin
            check("unexpected_race", 32'(1), 32'(0));
          end
        end
        if (done) begin
          check("done_one_cycle", 32'(done_prev), 32'(0));
          if (res_q.size() > 0) begin
            e = res_q.pop_front();
            check("response", 32'(response), 32'(e.resp));
            check("err_tmo", 32'(err_tmo), 32'(e.tmo));
            check("err_tie", 32'(err_tie), 32'(e.tie));
            if (e.lat >= 0) check("latency", 32'(busy_cyc), 32'(e.lat));
          end else begin
            check("unexpected_done", 32'(1), 32'(0));
          end
        end
        en_prev   = ro_en;
        done_prev = done;
      end
    end
  end

  // Reference outcome: faster oscillator wins, equal live rates tie,
  // two static oscillators time out.
  task automatic predict(input int chal, input int lat, input int nraces, output exp_t e);
    logic t, tie_b, bv;
    e.resp = '0; e.tmo = 1'b0; e.tie = 1'b0; e.lat = lat;
    for (int b = 0; b < NB; b++) begin
      t     = (h1_arr[b] == 0) && (h2_arr[b] == 0);
      tie_b = !t && (h1_arr[b] == h2_arr[b]);
      bv    = !t && !tie_b && ((h2_arr[b] == 0) || (h1_arr[b] != 0 && h1_arr[b] < h2_arr[b]));
      e.resp[b] = bv;
      e.tmo = e.tmo | t;
      e.tie = e.tie | tie_b;
      if (b < nraces) pair_q.push_back((chal + b) % (1 << SELW));
    end
  endtask

  task automatic issue_start(input int chal);
    @(negedge clk);
    challenge = SELW'(chal);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    challenge = SELW'($urandom);
    check("busy_after_start", 32'(busy), 32'(1));
  endtask

  task automatic run_seq(input int chal, input int lat, input bit poke);
    exp_t e;
    int   cnt;
    predict(chal, lat, NB, e);
    res_q.push_back(e);
    issue_start(chal);
    if (poke) begin
      repeat (50) @(negedge clk);
      challenge = SELW'(chal + 3);
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
    end
    cnt = 0;
    while (busy && cnt < 40000) begin
      @(negedge clk);
      cnt++;
    end
    if (busy) check("seq_timeout", 32'(1), 32'(0));
    check("done_low_in_idle", 32'(done), 32'(0));
    repeat (3) @(negedge clk);
    check("response_hold", 32'(response), 32'(e.resp));
    check("err_hold", 32'({err_tmo, err_tie}), 32'({e.tmo, e.tie}));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_ro_en"}, 32'(ro_en), 32'(0));
    check({tag, "_response"}, 32'(response), 32'(0));
    check({tag, "_errs"}, 32'({err_tmo, err_tie}), 32'(0));
    check({tag, "_pair_sel"}, 32'(pair_sel), 32'(0));
    check({tag, "_arb_out"}, 32'({arb_out_1, arb_out_2}), 32'(0));
    check({tag, "_arb_rst"}, 32'(arb_rst), 32'(1));
  endtask

  task automatic set_all(input int a, input int b);
    for (int i = 0; i < NB; i++) begin
      h1_arr[i] = a;
      h2_arr[i] = b;
    end
  endtask

  initial begin : stim
    exp_t dummy;
    int   cnt;
    set_all(1, 3);
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // ro_1 three times faster than ro_2: every bit is 1
    set_all(1, 3);
    run_seq(0, -1, 1'b0);

    // identical oscillators: every race ties
    set_all(1, 1);
    run_seq(2, -1, 1'b0);

    // challenge 6 with a start pulse while busy
    for (int i = 0; i < NB; i++) begin
      h1_arr[i] = $urandom_range(2, 1);
      h2_arr[i] = 3 - h1_arr[i];
    end
    run_seq(6, -1, 1'b1);

    // asynchronous reset in the middle of the fourth race
    set_all(2, 1);
    for (int i = 0; i < 3; i++) begin
      h1_arr[i] = 1;
      h2_arr[i] = 1;
    end
    h1_arr[3] = 3;
    h2_arr[3] = 3;
    predict(1, -1, 4, dummy);
    issue_start(1);
    cnt = 0;
    while (!(drv_bit == 3 && ro_en) && cnt < 10000) begin
      @(negedge clk);
      cnt++;
    end
    check("reached_bit3", 32'(drv_bit == 3 && ro_en), 32'(1));
    repeat (100) @(negedge clk);
    check("err_tie_before_reset", 32'(err_tie), 32'(1));
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midrace");
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("held");
    check("pair_q_drained", 32'(pair_q.size()), 32'(0));
    rst = 1'b1;
    pair_q.delete();
    @(negedge clk);
    run_seq(1, -1, 1'b0);

    // randomized challenges and oscillator rates (ties possible)
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NB; i++) begin
        h1_arr[i] = $urandom_range(2, 1);
        h2_arr[i] = $urandom_range(2, 1);
      end
      run_seq($urandom_range(7, 0), -1, 1'b0);
    end

    // static oscillators: every race times out after 2^TMOW-1 cycles
    set_all(0, 0);
    run_seq(5, NB * (2 + (1 << TMOW) - 1) + 1, 1'b0);

    repeat (3) @(negedge clk);
    check("res_q_empty", 32'(res_q.size()), 32'(0));
    check("pair_q_empty", 32'(pair_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_puf_challenge_ctrl
`default_nettype wire
